// File: rtl/apb_rr_pkg.sv
// ----------------------------------------------------------------------------
// apb_rr_pkg
//   Shared types and default widths for the round-robin APB master.
//   - apb_rr_state_t : bus sequencer state (IDLE -> SETUP -> ACCESS -> IDLE)
//   - DEF_*          : default parameter values used by apb_rr_master
// ----------------------------------------------------------------------------
package apb_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_rr_state_t;

  localparam int unsigned DEF_N_REQ          = 2;
  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Scans requesters starting at
//   last_grant+1 and wrapping modulo N_REQ; the first asserted request wins.
// Ports
//   req        in   N_REQ            request vector
//   last_grant in   $clog2(N_REQ)    index of the most recently served requester
//   grant      out  N_REQ            one-hot winner (all zero when no request)
//   grant_idx  out  $clog2(N_REQ)    binary index of the winner
//   grant_any  out  1                at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_any
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  always_comb begin : arb
    int unsigned cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Offset 1 first so the last winner has the lowest priority this round.
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last_grant) + off) % N_REQ;
      if (!grant_any && req[IDX_W'(cand)]) begin
        grant_any              = 1'b1;
        grant_idx              = IDX_W'(cand);
        grant[IDX_W'(cand)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// ----------------------------------------------------------------------------
// apb_rr_master
//   Round-robin APB master: shares one APB slave between N_REQ requesters
//   with simple valid/ready request and one-cycle response channels.
//   Sequences SETUP -> ACCESS and returns prdata/pslverr to the winner.
//   All outputs are registered.
// Configuration macro
//   APB_RR_TIMEOUT_EN : when defined, an ACCESS phase that sees no pready for
//                       TIMEOUT_CYCLES cycles is aborted with rsp_err=1.
// Ports
//   pclk, presetn         clock / synchronous active-low reset
//   req_valid/req_write   per-requester request and direction
//   req_addr/req_wdata    packed payloads, requester i at [i*W +: W]
//   req_ready             one-cycle one-hot accept pulse
//   rsp_valid             one-cycle one-hot completion pulse
//   rsp_rdata/rsp_err     response data (0 for writes/errors) and error flag
//   psel/penable/pwrite/paddr/pwdata   APB request side
//   pready/pslverr/prdata              APB response side
// ----------------------------------------------------------------------------
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int unsigned N_REQ          = DEF_N_REQ,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_rr_master: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // Read data is only meaningful for a successful read.
  function automatic logic [DATA_W-1:0] mask_rdata(input logic wr,
                                                   input logic err,
                                                   input logic [DATA_W-1:0] d);
    return (!wr && !err) ? d : '0;
  endfunction

  apb_rr_state_t     state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  cur_idx;

  logic [N_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

`ifdef APB_RR_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  // The stalled edge that would bring the count to TIMEOUT_CYCLES is the
  // abort edge, so ACCESS lasts exactly TIMEOUT_CYCLES cycles without pready.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      cur_idx    <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
`ifdef APB_RR_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        // IDLE: arbitrate and latch the winner's payload
        ST_IDLE: begin
          if (arb_any) begin
            req_ready <= arb_grant;
            cur_idx   <= arb_idx;
            pwrite    <= req_write[arb_idx];
            paddr     <= req_addr[arb_idx*ADDR_W +: ADDR_W];
            pwdata    <= req_wdata[arb_idx*DATA_W +: DATA_W];
            psel      <= 1'b1;
            penable   <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        // SETUP: single cycle, then raise penable
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
`ifdef APB_RR_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        // ACCESS: hold the bus until pready (or timeout abort)
        ST_ACCESS: begin
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= N_REQ'(1) << cur_idx;
            rsp_err    <= pslverr;
            rsp_rdata  <= mask_rdata(pwrite, pslverr, prdata);
            last_grant <= cur_idx;
            state      <= ST_IDLE;
          end
`ifdef APB_RR_TIMEOUT_EN
          else if (tmo_hit) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= N_REQ'(1) << cur_idx;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
            last_grant <= cur_idx;
            state      <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic                    pclk = 1'b0;
  logic                    presetn;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic                    psel, penable, pwrite;
  logic [ADDR_W-1:0]       paddr;
  logic [DATA_W-1:0]       pwdata;
  logic                    pready, pslverr;
  logic [DATA_W-1:0]       prdata;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_rr_master #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 60)
        $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave: group/date/surname/name registers ----------
  logic [31:0] regs [4];
  bit          slave_stall = 1'b0;

  always @(posedge pclk) begin
    if (!presetn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      regs[0] <= 32'h0000_0007;
      regs[1] <= 32'h1999_0101;
      regs[2] <= 32'h534D_4954;
      regs[3] <= 32'h4A4F_484E;
    end else if (psel && penable && !pready && !slave_stall) begin
      pready <= 1'b1;
      if (paddr < 32'h10 && paddr[1:0] == 2'b00) begin
        pslverr <= 1'b0;
        if (pwrite) begin
          regs[paddr[3:2]] <= pwdata;
          prdata <= 32'hA5A5_A5A5;   // junk: a write must still return 0
        end else begin
          prdata <= regs[paddr[3:2]];
        end
      end else begin
        pslverr <= 1'b1;
        prdata  <= 32'hDEAD_BEEF;    // junk: an error must still return 0
      end
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end
  end

  // ---------------- transaction-level reference model ---------------------
  bit                 model_started = 1'b0;
  logic [N_REQ-1:0]   exp_req_ready, exp_rsp_valid;
  logic [DATA_W-1:0]  exp_rsp_rdata;
  logic               exp_rsp_err, exp_psel, exp_penable, exp_pwrite;
  logic [ADDR_W-1:0]  exp_paddr;
  logic [DATA_W-1:0]  exp_pwdata;
  int                 m_last, m_req, m_waits;
  bit                 m_busy, m_access;

  always @(posedge pclk) begin
    bit found;
    found = 1'b0;
    model_started = 1'b1;
    exp_req_ready = '0;
    exp_rsp_valid = '0;
    exp_rsp_rdata = '0;
    exp_rsp_err   = 1'b0;
    if (!presetn) begin
      m_busy = 0; m_access = 0; m_last = N_REQ - 1; m_req = 0; m_waits = 0;
      exp_psel = 0; exp_penable = 0; exp_pwrite = 0; exp_paddr = '0; exp_pwdata = '0;
    end else if (!m_busy) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_last + k) % N_REQ;
        if (!found && req_valid[c]) begin
          found = 1'b1;
          m_req = c;
        end
      end
      if (found) begin
        m_busy = 1; m_access = 0;
        exp_req_ready[m_req] = 1'b1;
        exp_psel    = 1'b1;
        exp_penable = 1'b0;
        exp_pwrite  = req_write[m_req];
        exp_paddr   = req_addr[m_req*ADDR_W +: ADDR_W];
        exp_pwdata  = req_wdata[m_req*DATA_W +: DATA_W];
      end
    end else if (!m_access) begin
      m_access = 1; m_waits = 0;
      exp_penable = 1'b1;
    end else begin
      bit abrt;
      abrt = 1'b0;
      if (!pready) begin
        m_waits++;
`ifdef APB_RR_TIMEOUT_EN
        if (m_waits == TMO) abrt = 1'b1;
`endif
      end
      if (pready || abrt) begin
        exp_psel = 0; exp_penable = 0;
        exp_rsp_valid[m_req] = 1'b1;
        exp_rsp_err   = abrt ? 1'b1 : pslverr;
        exp_rsp_rdata = (abrt || exp_pwrite || pslverr) ? '0 : prdata;
        m_last = m_req;
        m_busy = 0;
      end
    end
  end

  // ---------------- per-cycle compare -------------------------------------
  always @(negedge pclk) begin
    if (model_started) begin
      check("psel",      64'(psel),      64'(exp_psel));
      check("penable",   64'(penable),   64'(exp_penable));
      check("pwrite",    64'(pwrite),    64'(exp_pwrite));
      check("paddr",     64'(paddr),     64'(exp_paddr));
      check("pwdata",    64'(pwdata),    64'(exp_pwdata));
      check("req_ready", 64'(req_ready), 64'(exp_req_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
      if (exp_rsp_valid != '0) begin
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp_rdata));
        check("rsp_err",   64'(rsp_err),   64'(exp_rsp_err));
      end
    end
  end

  // grant log, taken from the DUT's accept pulses
  int glog[$];
  always @(negedge pclk) begin
    if (model_started && presetn)
      for (int k = 0; k < N_REQ; k++)
        if (req_ready[k]) glog.push_back(k);
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat);
    int c;
    bit ok;
    rdata = '0; err = 1'b0; lat = -1;
    set_req(i, wr, a, d);
    req_valid[i] = 1'b1;
    ok = 0; c = 0;
    while (!ok && c < 20) begin
      @(negedge pclk); c++;
      if (req_ready[i]) ok = 1;
    end
    req_valid[i] = 1'b0;
    if (!ok) begin check("accept_timeout", 64'd0, 64'd1); return; end
    ok = 0; c = 0;
    while (!ok && c < 60) begin
      @(negedge pclk); c++;
      if (rsp_valid[i]) begin ok = 1; rdata = rsp_rdata; err = rsp_err; lat = c; end
    end
    if (!ok) check("response_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ready(input int i);
    int c;
    bit ok;
    ok = 0; c = 0;
    while (!ok && c < 20) begin
      @(negedge pclk); c++;
      if (req_ready[i]) ok = 1;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, c;
    bit          ok;

    presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge pclk);
    check("rst_psel",      64'(psel),      64'd0);
    check("rst_penable",   64'(penable),   64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_paddr",     64'(paddr),     64'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // 1: write then read back through requester 0
    xfer(0, 1'b1, 32'h04, 32'h2024_1015, rd, er, lat);
    check("t1_wr_err",   64'(er),  64'd0);
    check("t1_wr_rdata", 64'(rd),  64'd0);
    check("t1_wr_lat",   64'(lat), 64'd3);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er, lat);
    check("t1_rd_err",   64'(er),  64'd0);
    check("t1_rd_rdata", 64'(rd),  64'h2024_1015);
    check("t1_rd_lat",   64'(lat), 64'd3);

    // 2: both requesters hold valid from reset
    do_reset();
    glog.delete();
    set_req(0, 1'b0, 32'h08, 32'h0);
    set_req(1, 1'b0, 32'h0C, 32'h0);
    req_valid = 2'b11;
    c = 0;
    while (glog.size() < 4 && c < 100) begin @(negedge pclk); c++; end
    req_valid = 2'b00;
    repeat (10) @(negedge pclk);
    check("t2_grants", 64'(glog.size()), 64'd4);
    if (glog.size() >= 4) begin
      check("t2_g0", 64'(glog[0]), 64'd0);
      check("t2_g1", 64'(glog[1]), 64'd1);
      check("t2_g2", 64'(glog[2]), 64'd0);
      check("t2_g3", 64'(glog[3]), 64'd1);
    end

    // 3: unmapped read from requester 1
    xfer(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("t3_err",   64'(er), 64'd1);
    check("t3_rdata", 64'(rd), 64'd0);

    // 4: reset during ACCESS
    set_req(0, 1'b1, 32'h08, 32'h1234_5678);
    req_valid[0] = 1'b1;
    wait_ready(0);
    req_valid[0] = 1'b0;
    ok = 0; c = 0;
    while (!ok && c < 10) begin
      if (psel && penable) ok = 1; else begin @(negedge pclk); c++; end
    end
    check("t4_in_access", 64'(ok), 64'd1);
    presetn = 1'b0;
    @(negedge pclk);
    check("t4_psel",      64'(psel),      64'd0);
    check("t4_penable",   64'(penable),   64'd0);
    check("t4_rsp_valid", 64'(rsp_valid), 64'd0);
    presetn = 1'b1;
    set_req(0, 1'b0, 32'h00, 32'h0);
    set_req(1, 1'b0, 32'h00, 32'h0);
    req_valid = 2'b11;
    ok = 0; c = 0;
    while (!ok && c < 20) begin
      @(negedge pclk); c++;
      if (req_ready != '0) ok = 1;
    end
    req_valid = 2'b00;
    check("t4_first_grant", 64'(req_ready), 64'b01);
    repeat (8) @(negedge pclk);

    // 5: slave never answers
    slave_stall = 1'b1;
    set_req(0, 1'b0, 32'h00, 32'h0);
    req_valid[0] = 1'b1;
    wait_ready(0);
    req_valid[0] = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
    ok = 0; c = 0; lat = 0;
    while (!ok && c < 60) begin
      @(negedge pclk); c++;
      if (psel && penable) lat++;
      if (rsp_valid[0]) begin ok = 1; rd = rsp_rdata; er = rsp_err; end
    end
    check("t5_abort_seen",   64'(ok),   64'd1);
    check("t5_access_cycles", 64'(lat), 64'(TMO));
    check("t5_err",          64'(er),   64'd1);
    check("t5_rdata",        64'(rd),   64'd0);
    check("t5_psel_low",     64'(psel), 64'd0);
`else
    repeat (40) @(negedge pclk);
    check("t5_psel_held",    64'(psel),    64'd1);
    check("t5_penable_held", 64'(penable), 64'd1);
    do_reset();
`endif
    slave_stall = 1'b0;
    repeat (3) @(negedge pclk);

    // 6: requester 1 withdraws while requester 0 is on the bus
    glog.delete();
    set_req(0, 1'b1, 32'h0C, 32'hCAFE_0006);
    set_req(1, 1'b0, 32'h00, 32'h0);
    req_valid[0] = 1'b1;
    wait_ready(0);
    req_valid[0] = 1'b0;
    @(negedge pclk);
    req_valid[1] = 1'b1;
    @(negedge pclk);
    req_valid[1] = 1'b0;
    ok = 0; c = 0;
    while (!ok && c < 20) begin
      if (rsp_valid[0]) ok = 1; else begin @(negedge pclk); c++; end
    end
    check("t6_req0_done", 64'(ok), 64'd1);
    repeat (6) @(negedge pclk);
    check("t6_grants", 64'(glog.size()), 64'd1);
    check("t6_psel",   64'(psel),        64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
